// File: rtl/audio_delay_if.sv
// Sample-stream bundle for the echo/delay effect: input sample and controls
// flow from the source (master) into the effect (slave), and the blended sample flows back.
interface audio_delay_if #(
  parameter int SIG_BITS = 16,
  parameter int BLEND_B  = 10,
  parameter int DLY_B    = 14,
  parameter int FDB_B    = 10
);
  logic signed [SIG_BITS-1:0] in;
  logic signed [SIG_BITS-1:0] out;
  logic [BLEND_B-1:0]         blend;
  logic [DLY_B-1:0]           delay;
  logic [FDB_B-1:0]           feedbk;

  modport master (output in, output blend, output delay, output feedbk, input out);
  modport slave  (input in, input blend, input delay, input feedbk, output out);
endinterface

// File: rtl/audio_delay.sv
// Echo/delay effect: one signed sample per clock is mixed with a feedback-scaled
// copy of the delayed signal and stored in a circular buffer; the output is a
// registered dry/wet blend of the current input and the delayed tap.
module audio_delay #(
  parameter int SIG_BITS = 16,
  parameter int BLEND_B  = 10,
  parameter int DLY_B    = 14,
  parameter int FDB_B    = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  audio_delay_if.slave aud_if
);
  localparam int DEPTH = 2 ** DLY_B;
  localparam int GW    = (BLEND_B > FDB_B) ? BLEND_B : FDB_B;
  // Arithmetic width: sample plus gain bits plus two guard bits.
  localparam int AW    = SIG_BITS + GW + 2;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-SIG_BITS+1){1'b0}}, {(SIG_BITS-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [AW-1:0] BL_ONE  = {{(AW-BLEND_B-1){1'b0}}, 1'b1, {BLEND_B{1'b0}}};
  localparam logic [DLY_B:0]       FILL_FULL = {1'b1, {DLY_B{1'b0}}};

  logic [DLY_B-1:0]           wr_ptr_q;
  logic [DLY_B-1:0]           dly_q;
  logic [DLY_B-1:0]           dly_eff_d;
  logic [DLY_B-1:0]           rd_addr_d;
  logic [DLY_B:0]             fill_q;
  logic signed [SIG_BITS-1:0] mem_q [DEPTH];
  logic signed [SIG_BITS-1:0] rd_data_q;
  logic signed [SIG_BITS-1:0] tap_d;
  logic signed [SIG_BITS-1:0] w_d;
  logic signed [SIG_BITS-1:0] out_d;
  logic signed [SIG_BITS-1:0] out_q;
  logic                       tap_valid;
  logic signed [AW-1:0]       x_ext;
  logic signed [AW-1:0]       tap_ext;
  logic signed [AW-1:0]       fb_gain;
  logic signed [AW-1:0]       wet_gain;
  logic signed [AW-1:0]       dry_gain;
  logic signed [AW-1:0]       fb_prod;
  logic signed [AW-1:0]       w_sum;
  logic signed [AW-1:0]       mix_sum;

  // Clamp a wide signed value into the sample range.
  function automatic logic signed [SIG_BITS-1:0] sat(input logic signed [AW-1:0] v);
    logic signed [SIG_BITS-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[SIG_BITS-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[SIG_BITS-1:0];
    else                  r = v[SIG_BITS-1:0];
    return r;
  endfunction

  // Effective delay (minimum 2) and the prefetch address for next cycle's tap.
  // With D >= 2 the prefetched word was written at least one edge earlier and
  // never collides with the word written at the same edge, so no forwarding is needed.
  always_comb begin
    dly_eff_d = (aud_if.delay < DLY_B'(2)) ? DLY_B'(2) : aud_if.delay;
    rd_addr_d = wr_ptr_q + DLY_B'(1) - dly_eff_d;
  end

  // Tap gating, feedback write value and dry/wet output mix.
  always_comb begin
    tap_valid = (fill_q >= {1'b0, dly_q});
    tap_d     = tap_valid ? rd_data_q : '0;
    x_ext     = {{(AW-SIG_BITS){aud_if.in[SIG_BITS-1]}}, aud_if.in};
    tap_ext   = {{(AW-SIG_BITS){tap_d[SIG_BITS-1]}}, tap_d};
    fb_gain   = {{(AW-FDB_B){1'b0}}, aud_if.feedbk};
    wet_gain  = {{(AW-BLEND_B){1'b0}}, aud_if.blend};
    dry_gain  = BL_ONE - wet_gain;
    fb_prod   = fb_gain * tap_ext;
    w_sum     = x_ext + (fb_prod >>> FDB_B);
    mix_sum   = ((dry_gain * x_ext) + (wet_gain * tap_ext)) >>> BLEND_B;
    w_d       = sat(w_sum);
    out_d     = sat(mix_sum);
  end

  // Delay control is registered every cycle, so a change takes effect next cycle.
  always_ff @(posedge clk) begin
    dly_q <= dly_eff_d;
  end

  // Circular buffer: one write per sample, one registered read of next cycle's tap.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      mem_q[wr_ptr_q] <= w_d;
    end
    rd_data_q <= mem_q[rd_addr_d];
  end

  // Write pointer, saturating fill count and registered output sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + DLY_B'(1);
      if (fill_q != FILL_FULL) begin
        fill_q <= fill_q + (DLY_B+1)'(1);
      end
      out_q <= out_d;
    end
  end

  assign aud_if.out = out_q;

endmodule

// File: tb/tb_audio_delay.sv
// Self-checking bench for audio_delay: constant-vector table, spec scenarios
// and randomized traffic compared against a sample-history reference model.
module tb_audio_delay;
  localparam int SIG_BITS = 16;
  localparam int BLEND_B  = 10;
  localparam int DLY_B    = 14;
  localparam int FDB_B    = 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  audio_delay_if #(.SIG_BITS(SIG_BITS), .BLEND_B(BLEND_B), .DLY_B(DLY_B), .FDB_B(FDB_B)) bus ();

  audio_delay #(.SIG_BITS(SIG_BITS), .BLEND_B(BLEND_B), .DLY_B(DLY_B), .FDB_B(FDB_B)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .aud_if  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: every written value indexed by sample number since reset.
  int hist [65536];
  int m_n     = 0;
  int m_dly   = 2;
  int exp_out = 0;
  int trace [0:199];

  typedef struct {
    bit rn;
    int x;
    int bl;
    int dl;
    int fb;
    int exp;
  } vec_t;
  vec_t vecs[$];

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_step(input bit rn, input int x, input int bl, input int dl, input int fb);
    int dd;
    int d;
    int w;
    if (!rn) begin
      m_n     = 0;
      exp_out = 0;
    end else begin
      dd = (m_dly < 2) ? 2 : m_dly;
      d  = (m_n >= dd) ? hist[(m_n - dd) % 65536] : 0;
      w  = sat16(x + ((fb * d) >>> 10));
      hist[m_n % 65536] = w;
      m_n = m_n + 1;
      exp_out = sat16((((1024 - bl) * x) + (bl * d)) >>> 10);
    end
    m_dly = dl;
  endfunction

  function automatic int dut_out();
    logic signed [15:0] o;
    o = bus.out;
    return int'(o);
  endfunction

  function automatic void check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic int rand_sample();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic tick(input bit rn, input int x, input int bl, input int dl, input int fb);
    reset_n    = rn;
    bus.in     = 16'(x);
    bus.blend  = 10'(bl);
    bus.delay  = 14'(dl);
    bus.feedbk = 10'(fb);
    @(posedge clk);
    model_step(rn, x, bl, dl, fb);
    #1;
  endtask

  // Reset, impulse of 16384 in the first cycle, then silence; each output is
  // checked against the model and recorded in trace[k] (k = cycles after impulse).
  task automatic impulse_run(input string name, input int bl, input int dl, input int fb, input int ncyc);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, bl, dl, fb);
    for (int k = 1; k <= ncyc; k++) begin
      tick(1'b1, (k == 1) ? 16384 : 0, bl, dl, fb);
      trace[k] = dut_out();
      check($sformatf("%s model c%0d", name, k), trace[k], exp_out);
    end
    $display("[TB] %s: %0d cycles after impulse", name, ncyc);
  endtask

  // Compare the recorded trace with the spec: val[j] at pos[j], zero elsewhere.
  task automatic expect_taps(input string name, input int ncyc, input int pos[$], input int val[$]);
    int e;
    for (int k = 1; k <= ncyc; k++) begin
      e = 0;
      foreach (pos[j]) if (pos[j] == k) e = val[j];
      check($sformatf("%s c%0d", name, k), trace[k], e);
    end
  endtask

  initial begin
    bus.in     = '0;
    bus.blend  = '0;
    bus.delay  = 14'd3;
    bus.feedbk = '0;

    // Cycle-by-cycle vectors with hand-derived expected outputs (delay 3).
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1000, 0, 3, 0, 0});
    vecs.push_back('{1'b1, 1000,    0, 3,   0, 1000});
    vecs.push_back('{1'b1, 0,       0, 3,   0, 0});
    vecs.push_back('{1'b1, 0,       0, 3,   0, 0});
    vecs.push_back('{1'b1, 0,     512, 3,   0, 500});
    vecs.push_back('{1'b1, -2000, 512, 3, 512, -1000});
    vecs.push_back('{1'b1, 0,     256, 3, 512, 0});
    vecs.push_back('{1'b1, 0,     256, 3, 512, 0});
    vecs.push_back('{1'b1, 100,   256, 3, 512, -425});
    vecs.push_back('{1'b1, 0,    1023, 3,   0, 0});
    vecs.push_back('{1'b1, 0,    1023, 3,   0, 0});
    vecs.push_back('{1'b1, 0,    1023, 3,   0, -900});
    vecs.push_back('{1'b1, -1,      1, 3,   0, -1});

    foreach (vecs[i]) begin
      tick(vecs[i].rn, vecs[i].x, vecs[i].bl, vecs[i].dl, vecs[i].fb);
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
      $display("[TB] vec %0d rst_n=%0d in=%0d blend=%0d fb=%0d out=%0d", i,
               vecs[i].rn, vecs[i].x, vecs[i].bl, vecs[i].fb, dut_out());
    end

    // Dry path, single echo, feedback decay, minimum delay clamping.
    impulse_run("dry", 0, 100, 0, 110);
    expect_taps("dry", 110, '{1}, '{16384});
    impulse_run("echo", 512, 100, 0, 110);
    expect_taps("echo", 110, '{1, 101}, '{8192, 8192});
    impulse_run("feedback", 512, 10, 512, 45);
    expect_taps("feedback", 45, '{1, 11, 21, 31, 41}, '{8192, 8192, 4096, 2048, 1024});
    impulse_run("delay0", 512, 0, 0, 10);
    expect_taps("delay0", 10, '{1, 3}, '{8192, 8192});
    impulse_run("delay1", 512, 1, 0, 10);
    expect_taps("delay1", 10, '{1, 3}, '{8192, 8192});

    // Saturation under maximum feedback, both polarities.
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1023, 2, 1023);
    for (int k = 0; k < 50; k++) begin
      tick(1'b1, 32767, 1023, 2, 1023);
      check("sat_pos model", dut_out(), exp_out);
      check("sat_pos negative", (dut_out() < 0) ? 1 : 0, 0);
    end
    check("sat_pos settle", dut_out(), 32767);
    $display("[TB] sat_pos: out=%0d", dut_out());
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1023, 2, 1023);
    for (int k = 0; k < 50; k++) begin
      tick(1'b1, -32768, 1023, 2, 1023);
      check("sat_neg model", dut_out(), exp_out);
    end
    check("sat_neg settle", dut_out(), -32768);
    $display("[TB] sat_neg: out=%0d", dut_out());

    // Reset mid-run: stale buffer contents must never be heard.
    for (int k = 0; k < 30; k++) tick(1'b1, rand_sample(), 512, 10, 700);
    tick(1'b0, 0, 1023, 10, 1023);
    tick(1'b0, 0, 1023, 10, 1023);
    for (int k = 0; k < 15; k++) begin
      tick(1'b1, 0, 1023, 10, 1023);
      check($sformatf("stale c%0d", k), dut_out(), 0);
    end
    $display("[TB] reset mid-run: checked 15 cycles");

    // Maximum delay after pointer wrap.
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 1023, 16383, 0);
    for (int k = 0; k < 20001; k++) begin
      tick(1'b1, rand_sample(), 1023, 16383, 0);
      check("wrap warmup", dut_out(), exp_out);
    end
    tick(1'b1, 16384, 1023, 16383, 0);
    check("wrap impulse", dut_out(), exp_out);
    for (int k = 1; k <= 16384; k++) begin
      tick(1'b1, 0, 1023, 16383, 0);
      check("wrap model", dut_out(), exp_out);
      if (k == 16383) check("wrap echo", dut_out(), 16368);
      if (k == 16384) check("wrap after echo", dut_out(), 0);
    end
    $display("[TB] wrap: delay 16383 after 20001 warm-up samples");

    // Randomized traffic with changing controls and occasional resets.
    begin
      int dl;
      dl = 5;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 19) == 0) dl = $urandom_range(0, 40);
        tick(($urandom_range(0, 99) != 0), rand_sample(), $urandom_range(0, 1023), dl,
             $urandom_range(0, 1023));
        check($sformatf("random c%0d", k), dut_out(), exp_out);
      end
    end
    $display("[TB] random: 3000 cycles");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
